divide_sequential: RTL
======================

# divide_sequential

Sequential floating-point divider computing a / b on the team's extended operand format: exception field, sign, biased exponent, and stored mantissa without the hidden bit. It is the inverse counterpart of the multiply-accumulate datapath and accepts and returns words in exactly the same layout. It uses a radix-2 restoring mantissa iteration with a start/ready/valid handshake, so one shared divider can sit beside the combinational MAC without a large array divider.

## Interface
- size_exponent, 8, exponent bits
- size_mantissa, 24, mantissa bits including hidden 1
- size_counter, 5, iteration counter width; must satisfy 2^size_counter > size_mantissa
- size_exception_field, 2, exception field width
- zero, 0, exception code for zero
- normal_number, 1, exception code for a normal number
- infinity, 2, exception code for infinity
- NaN, 3, exception code for NaN
- size, size_exponent+size_mantissa+size_exception_field, operand word width
- Word layout, MSB first: {exception[size-1:size-2], sign, exponent[size_exponent-1:0], mantissa[size_mantissa-2:0]}
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset; asynchronous, active-high
- a_number_i  in  size  dividend; sampled only on an accepted start
- b_number_i  in  size  divisor; sampled only on an accepted start
- start_i  in  1  request; accepted when start_i=1 and ready_o=1
- ready_o  out  1  high in IDLE
- valid_o  out  1  one-cycle pulse when resulting_number_o updates
- resulting_number_o  out  size  quotient; held until the next result

## Operation
- States:
  - IDLE: ready_o=1.
  - DIVIDE: size_mantissa+1 iterations.
  - ROUND: one cycle.
- Transitions:
  - IDLE -> DIVIDE on an accepted start.
  - DIVIDE -> ROUND after the iteration with counter = size_mantissa.
  - ROUND -> IDLE unconditionally.
- Load (accepted start):
  - Mantissas are ma = {1, a mant} and mb = {1, b mant}.
  - Exponent register, signed with size_exponent+2 bits: e = ea - eb + (2^(size_exponent-1) - 1).
  - If ma < mb, the partial remainder loads ma<<1 and e is decremented. Otherwise it loads ma. This keeps the quotient in [1,2).
  - Counter loads 0. Sign register = sa ^ sb. Special-case classification is registered.
- DIVIDE iteration:
  - Compute r - mb. If it is non-negative, the quotient bit is 1 and r = (r - mb)<<1. Otherwise the quotient bit is 0 and r = r<<1.
  - The quotient bit is shifted into the LSB of a (size_mantissa+1)-bit quotient register.
  - The remainder register is size_mantissa+1 bits wide.
- ROUND:
  - Quotient bits [size_mantissa:1] form the mantissa with the hidden 1, bit 0 is the guard bit, and sticky = (r != 0).
  - Rounding is round-to-nearest-even: increment when guard & (sticky | mantissa LSB).
  - If the increment carries out, the mantissa becomes 1.0 and e is incremented.
- Exponent range:
  - If e >= 2^size_exponent - 1, the result is infinity.
  - If e <= 0, the result is flushed to zero.
- Special cases, by the exception fields; they override the computed value:
  - NaN if either operand is NaN, if both are zero, or if both are infinity.
  - Otherwise infinity if a is infinity or b is zero.
  - Otherwise zero if a is zero or b is infinity.
  - Otherwise normal_number.
- Encoding of non-normal results: exponent = 0, mantissa = 0, sign = sa ^ sb.
- Special-case operations still traverse DIVIDE and ROUND, so latency is fixed.

## Timing
- Reset values: state=IDLE, ready_o=1, valid_o=0, resulting_number_o=0, counter=0.
- Edge 0 accepts start. Edges 1..size_mantissa+1 perform the iterations. Edge size_mantissa+2 registers the result and sets valid_o=1. Latency is 26 cycles with the defaults.
- ready_o falls after edge 0 and returns high together with valid_o.
- start_i while ready_o=0 is ignored; the inputs are not sampled.
- A start accepted in the valid_o cycle is legal and gives back-to-back results every size_mantissa+2 cycles. valid_o drops on the next edge.
- Reset asserted mid-operation aborts immediately: the returns to reset values and no valid_o is produced.

## Test plan
- 6.0/2.0: a={01,0,8'h81,23'h400000}, b={01,0,8'h80,0} -> at 26 cycles, valid_o pulse with {01,0,8'h80,23'h400000}.
- 1.0/3.0: a={01,0,8'h7F,0}, b={01,0,8'h80,23'h400000} -> {01,0,8'h7D,23'h2AAAAB}, exercising the pre-shift and round-up.
- Specials: normal -2.0 / zero -> {10,1,0,0}; zero/zero -> {11,0,0,0}; 5.0 / infinity -> {00,0,0,0}; all with 26-cycle latency.
- Overflow: a exponent 8'hFE, b exponent 8'h01, both mantissas 0 -> {10,0,0,0}. Underflow with a exponent 8'h01, b exponent 8'hFE -> {00,0,0,0}.
- Handshake: pulse start_i again at cycles 5 and 20 of a busy operation -> ignored, a single valid_o. A start on the valid cycle -> second valid_o exactly 26 cycles later.
- Reset at cycle 10 of a division -> ready_o=1, valid_o=0, resulting_number_o=0 immediately, and no later valid_o.

Source files
------------

// File: rtl/divide_sequential.sv
// divide_sequential: radix-2 restoring floating-point divider on the extended
// operand word {exception, sign, exponent, mantissa-without-hidden-bit}.
module divide_sequential #(
  parameter int unsigned size_exponent        = 8,
  parameter int unsigned size_mantissa        = 24,
  parameter int unsigned size_counter         = 5,
  parameter int unsigned size_exception_field = 2,
  parameter logic [size_exception_field-1:0] zero          = 2'd0,
  parameter logic [size_exception_field-1:0] normal_number = 2'd1,
  parameter logic [size_exception_field-1:0] infinity      = 2'd2,
  parameter logic [size_exception_field-1:0] NaN           = 2'd3,
  parameter int unsigned size = size_exponent + size_mantissa + size_exception_field
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [size-1:0] a_number_i,
  input  logic [size-1:0] b_number_i,
  input  logic            start_i,
  output logic            ready_o,
  output logic            valid_o,
  output logic [size-1:0] resulting_number_o
);

  localparam int unsigned MW   = size_mantissa;
  localparam int unsigned EW   = size_exponent + 2;
  localparam int unsigned EXPH = size - size_exception_field - 2;
  localparam int unsigned BIAS = (2 ** (size_exponent - 1)) - 1;
  localparam int unsigned EMAX = (2 ** size_exponent) - 1;

  typedef enum logic [1:0] {IDLE, DIVIDE, ROUND} state_t;

  state_t                          state_q;
  logic [size_counter-1:0]         cnt_q;
  logic [MW:0]                     rem_q;
  logic [MW:0]                     quo_q;
  logic [MW-1:0]                   mb_q;
  logic signed [EW-1:0]            exp_q;
  logic                            sign_q;
  logic [size_exception_field-1:0] exc_q;

  // Operand unpacking and load-time values for an accepted start
  logic [size_exception_field-1:0] xa, xb, exc_load;
  logic [size_exponent-1:0]        ea, eb;
  logic [MW-1:0]                   ma, mb;
  logic                            pre_shift;
  logic signed [EW-1:0]            exp_load;

  always_comb begin
    xa        = a_number_i[size-1 -: size_exception_field];
    xb        = b_number_i[size-1 -: size_exception_field];
    ea        = a_number_i[EXPH -: size_exponent];
    eb        = b_number_i[EXPH -: size_exponent];
    ma        = {1'b1, a_number_i[MW-2:0]};
    mb        = {1'b1, b_number_i[MW-2:0]};
    pre_shift = (ma < mb);
    exp_load  = $signed(EW'(ea)) - $signed(EW'(eb)) + $signed(EW'(BIAS))
                - (pre_shift ? $signed(EW'(1)) : $signed(EW'(0)));
    if ((xa == NaN) || (xb == NaN) || ((xa == zero) && (xb == zero)) ||
        ((xa == infinity) && (xb == infinity)))
      exc_load = NaN;
    else if ((xa == infinity) || (xb == zero))
      exc_load = infinity;
    else if ((xa == zero) || (xb == infinity))
      exc_load = zero;
    else
      exc_load = normal_number;
  end

  // One restoring iteration: trial subtract, then shift the remainder
  logic          q_bit;
  logic [MW:0]   rem_sub, rem_next;

  always_comb begin
    q_bit    = (rem_q >= {1'b0, mb_q});
    rem_sub  = rem_q - {1'b0, mb_q};
    rem_next = q_bit ? (rem_sub << 1) : (rem_q << 1);
  end

  // Round-to-nearest-even, exponent range check and result packing
  logic                 guard, sticky, inc, carry;
  logic [MW:0]          mant_sum;
  logic [MW-2:0]        frac;
  logic signed [EW-1:0] exp_rnd;
  logic [size-1:0]      result;

  always_comb begin
    guard    = quo_q[0];
    sticky   = |rem_q;
    inc      = guard & (sticky | quo_q[1]);
    mant_sum = {1'b0, quo_q[MW:1]} + (MW+1)'(inc);
    carry    = mant_sum[MW];
    frac     = (MW-1)'(mant_sum);
    exp_rnd  = exp_q + (carry ? $signed(EW'(1)) : $signed(EW'(0)));
    if (exc_q != normal_number)
      result = {exc_q, sign_q, (size - size_exception_field - 1)'(0)};
    else if (exp_rnd >= $signed(EW'(EMAX)))
      result = {infinity, sign_q, (size - size_exception_field - 1)'(0)};
    else if (exp_rnd <= $signed(EW'(0)))
      result = {zero, sign_q, (size - size_exception_field - 1)'(0)};
    else
      result = {normal_number, sign_q, size_exponent'(exp_rnd), frac};
  end

  // Control FSM with datapath registers and registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q            <= IDLE;
      cnt_q              <= '0;
      rem_q              <= '0;
      quo_q              <= '0;
      mb_q               <= '0;
      exp_q              <= '0;
      sign_q             <= 1'b0;
      exc_q              <= zero;
      ready_o            <= 1'b1;
      valid_o            <= 1'b0;
      resulting_number_o <= '0;
    end else begin
      valid_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= DIVIDE;
            ready_o <= 1'b0;
            cnt_q   <= '0;
            rem_q   <= pre_shift ? {ma, 1'b0} : {1'b0, ma};
            quo_q   <= '0;
            mb_q    <= mb;
            exp_q   <= exp_load;
            sign_q  <= a_number_i[size-size_exception_field-1] ^
                       b_number_i[size-size_exception_field-1];
            exc_q   <= exc_load;
          end
        end
        DIVIDE: begin
          rem_q <= rem_next;
          quo_q <= {quo_q[MW-1:0], q_bit};
          cnt_q <= cnt_q + size_counter'(1);
          if (cnt_q == size_counter'(MW))
            state_q <= ROUND;
        end
        ROUND: begin
          resulting_number_o <= result;
          valid_o            <= 1'b1;
          ready_o            <= 1'b1;
          state_q            <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule
